// File: rtl/io_dma_buffer.sv
// Peripheral buffer FIFO: filled by a device port or CPU writes, drained by CPU reads or
// by a dreq/dack DMA burst that is requested once the fill level reaches a threshold.
module io_dma_buffer #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int BURST_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              wr,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              dev_valid,
  input  logic [DATA_W-1:0] dev_data,
  output logic              dev_ready,
  output logic              dreq,
  input  logic              dack,
  output logic              dma_valid,
  output logic [DATA_W-1:0] dma_data,
  output logic              dma_last
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int BL_W  = $clog2(BURST_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_BURST, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                en_q, en_d, ovf_q, ovf_d;
  logic [7:0]          thresh_q, thresh_d, thresh_eff;
  logic [BL_W-1:0]     blen_q, blen_d, beat_q, beat_d, blen_new;
  logic [DATA_W-1:0]   rdata_q, rdata_d, dma_data_q, dma_data_d;
  logic                dma_valid_q, dma_valid_d, dma_last_q, dma_last_d;
  logic [DATA_W-1:0]   status, ctrl_rd, head, push_data;
  logic                cpu_rd, cpu_wr, clr_wr, abort, empty, full, thr_met;
  logic                dma_hold, cpu_pop_req, cpu_push_req, cpu_pop, dma_pop;
  logic                push, pop, ovf_set;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign cpu_rd       = cs & ~wr;
  assign cpu_wr       = cs & wr;
  assign clr_wr       = cpu_wr & (addr == 2'd1) & wdata[1];
  assign en_d         = (cpu_wr && addr == 2'd1) ? wdata[0] : en_q;
  assign thresh_d     = (cpu_wr && addr == 2'd1) ? wdata[15:8] : thresh_q;
  assign abort        = clr_wr | ~en_d;
  assign empty        = (count_q == '0);
  assign full         = (count_q == CNT_W'(DEPTH));
  assign thresh_eff   = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  assign thr_met      = 32'(count_q) >= 32'(thresh_eff);
  assign head         = mem_q[rptr_q];
  assign dev_ready    = ~full & ~(cpu_wr & (addr == 2'd2)) & ~clr_wr;

  // The grant cycle already belongs to the burst, so blen never exceeds the words present.
  assign dma_hold     = ~abort & ((state_q == S_BURST) | ((state_q == S_REQ) & dack));
  assign cpu_pop_req  = cpu_rd & (addr == 2'd2);
  assign cpu_push_req = cpu_wr & (addr == 2'd2);
  assign cpu_pop      = cpu_pop_req & ~empty & ~dma_hold;
  assign dma_pop      = (state_q == S_BURST) & dack & ~abort & ~empty;
  assign pop          = cpu_pop | dma_pop;
  assign push         = (cpu_push_req | (dev_valid & dev_ready)) & (~full | pop);
  assign push_data    = cpu_push_req ? wdata : dev_data;
  assign ovf_set      = (cpu_push_req & full & ~pop) | (cpu_pop_req & dma_hold);
  assign blen_new     = (32'(count_q) >= BURST_MAX) ? BL_W'(BURST_MAX) : BL_W'(count_q);

  always_comb begin
    status            = '0;
    status[CNT_W-1:0] = count_q;
    status[16]        = empty;
    status[17]        = full;
    status[18]        = ovf_q;
    status[19]        = dreq;
    ctrl_rd           = '0;
    ctrl_rd[0]        = en_q;
    ctrl_rd[15:8]     = thresh_q;
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    rdata_d = rdata_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    if (clr_wr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
    if (cpu_rd && addr == 2'd0) ovf_d = 1'b0;
    if (ovf_set)                ovf_d = 1'b1;
    if (cpu_rd) begin
      case (addr)
        2'd0:    rdata_d = status;
        2'd1:    rdata_d = ctrl_rd;
        2'd2:    rdata_d = cpu_pop ? head : '0;
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    blen_d      = blen_q;
    beat_d      = beat_q;
    dma_valid_d = 1'b0;
    dma_last_d  = 1'b0;
    dma_data_d  = dma_data_q;
    case (state_q)
      S_IDLE: if (thr_met) state_d = S_REQ;
      S_REQ: begin
        if (dack) begin
          blen_d  = blen_new;
          beat_d  = '0;
          state_d = S_BURST;
        end else if (!thr_met) begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (dma_pop) begin
          dma_valid_d = 1'b1;
          dma_data_d  = head;
          beat_d      = beat_q + BL_W'(1);
          if (beat_q == blen_q - BL_W'(1)) begin
            dma_last_d = 1'b1;
            state_d    = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d     = S_IDLE;
      dma_valid_d = 1'b0;
      dma_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      en_q        <= 1'b0;
      thresh_q    <= '0;
      ovf_q       <= 1'b0;
      blen_q      <= '0;
      beat_q      <= '0;
      rdata_q     <= '0;
      dma_valid_q <= 1'b0;
      dma_data_q  <= '0;
      dma_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      en_q        <= en_d;
      thresh_q    <= thresh_d;
      ovf_q       <= ovf_d;
      blen_q      <= blen_d;
      beat_q      <= beat_d;
      rdata_q     <= rdata_d;
      dma_valid_q <= dma_valid_d;
      dma_data_q  <= dma_data_d;
      dma_last_q  <= dma_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

  assign dreq      = (state_q == S_REQ) || (state_q == S_BURST);
  assign rdata     = rdata_q;
  assign dma_valid = dma_valid_q;
  assign dma_data  = dma_data_q;
  assign dma_last  = dma_last_q;

endmodule

// File: tb/tb_io_dma_buffer.sv
// Bench for io_dma_buffer: directed steps with random data, checked against a queue-based
// model of the buffer contents, overflow flag and burst lengths.
module tb_io_dma_buffer;
  localparam int DEPTH     = 32;
  localparam int BURST_MAX = 16;

  logic        clk = 1'b0;
  logic        rst, cs, wr, dev_valid, dack;
  logic [1:0]  addr;
  logic [31:0] wdata, dev_data;
  logic [31:0] rdata, dma_data;
  logic        dev_ready, dreq, dma_valid, dma_last;

  io_dma_buffer #(.DATA_W(32), .DEPTH(DEPTH), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .addr(addr), .wdata(wdata), .rdata(rdata),
    .dev_valid(dev_valid), .dev_data(dev_data), .dev_ready(dev_ready), .dreq(dreq),
    .dack(dack), .dma_valid(dma_valid), .dma_data(dma_data), .dma_last(dma_last)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] mq[$];
  logic        ovf_m = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] stat_exp(input logic dr);
    logic [31:0] s;
    s     = 32'(mq.size());
    s[16] = (mq.size() == 0);
    s[17] = (mq.size() == DEPTH);
    s[18] = ovf_m;
    s[19] = dr;
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    step();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [31:0] d);
    cs = 1'b1; wr = 1'b0; addr = a;
    step();
    cs = 1'b0;
    d = rdata;
  endtask

  task automatic push_cpu(input logic [31:0] d);
    if (mq.size() < DEPTH) mq.push_back(d);
    else ovf_m = 1'b1;
    cpu_wr(2'd2, d);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e, d;
    e = 32'h0;
    if (mq.size() > 0) e = mq.pop_front();
    cpu_rd(2'd2, d);
    check(tag, d, e);
  endtask

  task automatic stat_check(input string tag, input logic dr);
    logic [31:0] e, d;
    e = stat_exp(dr);
    cpu_rd(2'd0, d);
    check(tag, d, e);
    ovf_m = 1'b0;
  endtask

  task automatic dev_push(input logic [31:0] d);
    dev_valid = 1'b1; dev_data = d;
    #1;
    check("dev_ready", dev_ready, mq.size() < DEPTH);
    @(posedge clk);
    #1;
    dev_valid = 1'b0;
    if (mq.size() < DEPTH) mq.push_back(d);
  endtask

  task automatic wait_dreq(input string tag, input int maxc);
    int n = 0;
    while (!dreq && n < maxc) begin
      step();
      n++;
    end
    check(tag, dreq, 1'b1);
  endtask

  task automatic run_burst(input int exp_len, input int pause_at, input int pause_len);
    int          got = 0, cyc = 0, paused = 0;
    logic        dk;
    logic [31:0] e;
    while (got < exp_len && cyc < 300) begin
      dk = !(got == pause_at && paused < pause_len);
      if (!dk) paused++;
      dack = dk;
      step();
      cyc++;
      if (!dk) check("pause_valid", dma_valid, 1'b0);
      else if (dma_valid) begin
        got++;
        e = 32'hDEAD_0000;
        if (mq.size() > 0) e = mq.pop_front();
        check("dma_data", dma_data, e);
        check("dma_last", dma_last, got == exp_len);
      end
    end
    dack = 1'b0;
    check("burst_len", got, exp_len);
    check("dreq_done", dreq, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    int          thr, n, blen, got, cyc;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; addr = 2'd0; wdata = '0;
    dev_valid = 1'b0; dev_data = '0; dack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_dreq", dreq, 1'b0);
    check("rst_dma_valid", dma_valid, 1'b0);
    check("rst_dma_data", dma_data, 32'h0);
    check("rst_dma_last", dma_last, 1'b0);
    check("rst_dev_ready", dev_ready, 1'b1);
    rst = 1'b0;
    step();
    stat_check("rst_status", 1'b0);

    // CPU push/pop round trip
    push_cpu(32'hA);
    push_cpu(32'hB);
    pop_check("t1_pop_a");
    pop_check("t1_pop_b");
    stat_check("t1_status", 1'b0);
    pop_check("t1_pop_empty");

    // Random CPU/device traffic with DMA disabled
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: push_cpu($urandom);
        5, 6, 7:       pop_check("rnd_pop");
        8:             stat_check("rnd_status", 1'b0);
        default:       dev_push($urandom);
      endcase
    end
    while (mq.size() > 0) pop_check("rnd_drain");

    // Fill to full, overflow, sticky flag cleared by STATUS read
    for (int i = 0; i < DEPTH; i++) push_cpu($urandom);
    stat_check("t3_full", 1'b0);
    check("t3_dev_ready_full", dev_ready, 1'b0);
    push_cpu(32'h3333_3333);
    stat_check("t3_ovf_set", 1'b0);
    stat_check("t3_ovf_clr", 1'b0);
    while (mq.size() > 0) pop_check("t3_drain");

    // Threshold 4 request and 4-word burst
    cpu_wr(2'd1, 32'h0000_0401);
    for (int i = 1; i <= 4; i++) dev_push(32'(i));
    check("t2_dreq_before", dreq, 1'b0);
    step();
    check("t2_dreq_after", dreq, 1'b1);
    run_burst(4, 0, 0);

    // 20 words queued: BURST_MAX burst, low gap, then burst of the remaining 4
    cpu_wr(2'd1, 32'h0000_0400);
    for (int i = 0; i < 20; i++) dev_push($urandom);
    cpu_wr(2'd1, 32'h0000_0401);
    wait_dreq("t4_dreq", 4);
    run_burst(BURST_MAX, 0, 0);
    step();
    check("t4_gap", dreq, 1'b0);
    step();
    check("t4_rereq", dreq, 1'b1);
    run_burst(4, 0, 0);

    // Threshold 8: paused burst, remainder below threshold raises no request
    cpu_wr(2'd1, 32'h0000_0800);
    for (int i = 0; i < 20; i++) dev_push($urandom);
    cpu_wr(2'd1, 32'h0000_0801);
    wait_dreq("t5_dreq", 4);
    run_burst(BURST_MAX, 5, 3);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_dreq", dreq, 1'b0);
    end
    while (mq.size() > 0) pop_check("t5_drain");

    // Random thresholds, lengths and pauses
    for (int k = 0; k < 3; k++) begin
      thr = $urandom_range(1, 6);
      n = $urandom_range(thr, 24);
      cpu_wr(2'd1, 32'(thr) << 8);
      for (int i = 0; i < n; i++) dev_push($urandom);
      cpu_wr(2'd1, (32'(thr) << 8) | 32'h1);
      wait_dreq("rb_dreq", 4);
      blen = (n < BURST_MAX) ? n : BURST_MAX;
      run_burst(blen, $urandom_range(1, blen), $urandom_range(0, 3));
      cpu_wr(2'd1, 32'(thr) << 8);
      while (mq.size() > 0) pop_check("rb_drain");
    end

    // CPU pop during a burst, then clear mid-burst
    cpu_wr(2'd1, 32'h0000_0401);
    for (int i = 0; i < 10; i++) dev_push($urandom);
    wait_dreq("t6_dreq", 4);
    dack = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 20) begin
      step();
      cyc++;
      if (dma_valid) begin
        got++;
        check("t6_dma_data", dma_data, mq.pop_front());
      end
    end
    check("t6_started", got, 2);
    cs = 1'b1; wr = 1'b0; addr = 2'd2;
    step();
    cs = 1'b0;
    ovf_m = 1'b1;
    check("t6_cpu_pop_rdata", rdata, 32'h0);
    check("t6_valid_during_pop", dma_valid, 1'b1);
    if (dma_valid) check("t6_dma_data_pop", dma_data, mq.pop_front());
    cpu_wr(2'd1, 32'h0000_0403);
    check("t6_clr_dreq", dreq, 1'b0);
    check("t6_clr_valid", dma_valid, 1'b0);
    dack = 1'b0;
    mq.delete();
    stat_check("t6_status", 1'b0);
    cpu_rd(2'd1, d);
    check("t6_ctrl", d, 32'h0000_0401);
    stat_check("t6_status2", 1'b0);

    // Asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) dev_push($urandom);
    wait_dreq("t7_dreq", 4);
    dack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t7_rst_dreq", dreq, 1'b0);
    check("t7_rst_valid", dma_valid, 1'b0);
    check("t7_rst_data", dma_data, 32'h0);
    check("t7_rst_last", dma_last, 1'b0);
    check("t7_rst_rdata", rdata, 32'h0);
    dack = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    mq.delete();
    ovf_m = 1'b0;
    stat_check("t7_status", 1'b0);
    cpu_rd(2'd1, d);
    check("t7_ctrl", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
